// File: rtl/exu_lsu_ctrl_pkg.sv
// Shared definitions for the EXU load/store sequencer: access size codes,
// FSM state encoding and the default bus timeout.
package exu_lsu_ctrl_pkg;

    localparam int unsigned TIMEOUT_CYC_DEF = 256;

    // funct3 encodings; bits [1:0] carry the access size for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RSP  = 2'b10
    } lsu_state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_H:    return off[0];
            SZ_W:    return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/exu_lsu_ctrl_if.sv
// Single-outstanding req/gnt/rvalid data bus between the LSU (master) and memory (slave).
interface exu_lsu_ctrl_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/exu_lsu_ctrl_lsu_data_align.sv
// Combinational lane handling: store byte-enable/replication and load
// extraction with sign or zero extension.
module exu_lsu_ctrl_lsu_data_align
    import exu_lsu_ctrl_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_lane,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);
    logic [31:0] lane;

    always_comb begin
        st_be   = 4'b1111;
        st_lane = st_data;
        case (st_size)
            SZ_B: begin
                st_be   = 4'b0001 << st_off;
                st_lane = {4{st_data[7:0]}};
            end
            SZ_H: begin
                st_be   = 4'b0011 << st_off;
                st_lane = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        lane    = ld_rdata >> {ld_off, 3'b000};
        ld_data = lane;
        case (ld_funct3)
            F3_B:    ld_data = {{24{lane[7]}}, lane[7:0]};
            F3_H:    ld_data = {{16{lane[15]}}, lane[15:0]};
            F3_BU:   ld_data = {24'b0, lane[7:0]};
            F3_HU:   ld_data = {16'b0, lane[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/exu_lsu_ctrl.sv
// Load/store sequencer: runs one EXU memory request at a time on the data bus,
// stalls the pipeline until the response, and returns extended load data.
module exu_lsu_ctrl
    import exu_lsu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic                 i_mem_wen,
    input  logic                 i_mem_ren,
    input  logic [31:0]          i_mem_addr,
    input  logic [2:0]           i_funct3,
    input  logic [31:0]          i_wdata,
    input  logic [4:0]           i_rd_addr,
    output logic                 o_stall,
    exu_lsu_ctrl_if.master       bus,
    output logic                 o_wb_valid,
    output logic [4:0]           o_wb_addr,
    output logic [31:0]          o_wb_data,
    output logic                 o_misalign,
    output logic                 o_bus_err
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYC) + 1;

    lsu_state_e    state;
    logic [CW-1:0] tmo_cnt;
    logic          bus_req_q;
    logic          cap_we;
    logic [31:0]   cap_addr;
    logic [3:0]    cap_be;
    logic [31:0]   cap_wdata;
    logic [2:0]    cap_funct3;
    logic [4:0]    cap_rd;

    logic          mem_op;
    logic          misaligned;
    logic          rsp_done;
    logic          tmo_hit;
    logic [3:0]    st_be;
    logic [31:0]   st_lane;
    logic [31:0]   ld_data;

    exu_lsu_ctrl_lsu_data_align u_lsu_data_align (
        .st_size   (i_funct3[1:0]),
        .st_off    (i_mem_addr[1:0]),
        .st_data   (i_wdata),
        .st_be     (st_be),
        .st_lane   (st_lane),
        .ld_funct3 (cap_funct3),
        .ld_off    (cap_addr[1:0]),
        .ld_rdata  (bus.rdata),
        .ld_data   (ld_data)
    );

    // Stall and the completion strobes are decided in the cycle the event is seen
    always_comb begin
        mem_op     = i_valid & (i_mem_wen | i_mem_ren);
        misaligned = is_misaligned(i_funct3[1:0], i_mem_addr[1:0]);
        rsp_done   = (state == RSP) & bus.rvalid;
        tmo_hit    = (state == RSP) & ~bus.rvalid & (tmo_cnt == CW'(TIMEOUT_CYC - 1));
        o_stall    = ((state == IDLE) & mem_op & ~misaligned) | (state == REQ) |
                     ((state == RSP) & ~rsp_done & ~tmo_hit);
        o_misalign = (state == IDLE) & mem_op & misaligned;
        o_bus_err  = tmo_hit;
        o_wb_valid = rsp_done & ~cap_we;
        o_wb_addr  = o_wb_valid ? cap_rd : '0;
        o_wb_data  = o_wb_valid ? ld_data : '0;
    end

    assign bus.req   = bus_req_q;
    assign bus.we    = cap_we;
    assign bus.addr  = {cap_addr[31:2], 2'b00};
    assign bus.be    = cap_be;
    assign bus.wdata = cap_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            bus_req_q  <= 1'b0;
            cap_we     <= 1'b0;
            cap_addr   <= '0;
            cap_be     <= '0;
            cap_wdata  <= '0;
            cap_funct3 <= '0;
            cap_rd     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op && !misaligned) begin
                        cap_we     <= i_mem_wen;
                        cap_addr   <= i_mem_addr;
                        cap_be     <= st_be;
                        cap_wdata  <= st_lane;
                        cap_funct3 <= i_funct3;
                        cap_rd     <= i_rd_addr;
                        bus_req_q  <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (bus.gnt) begin
                        bus_req_q <= 1'b0;
                        tmo_cnt   <= '0;
                        state     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_done || tmo_hit) begin
                        tmo_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exu_lsu_ctrl.sv
// Directed bench for exu_lsu_ctrl: load/store transactions, misalignment,
// bus timeout and reset abandonment, with a writeback scoreboard.
module tb_exu_lsu_ctrl;
    localparam int unsigned TMO = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_mem_wen;
    logic        i_mem_ren;
    logic [31:0] i_mem_addr;
    logic [2:0]  i_funct3;
    logic [31:0] i_wdata;
    logic [4:0]  i_rd_addr;
    logic        o_stall;
    logic        o_wb_valid;
    logic [4:0]  o_wb_addr;
    logic [31:0] o_wb_data;
    logic        o_misalign;
    logic        o_bus_err;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [36:0] sb_q[$];

    exu_lsu_ctrl_if bus ();

    exu_lsu_ctrl #(.TIMEOUT_CYC(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_mem_wen  (i_mem_wen),
        .i_mem_ren  (i_mem_ren),
        .i_mem_addr (i_mem_addr),
        .i_funct3   (i_funct3),
        .i_wdata    (i_wdata),
        .i_rd_addr  (i_rd_addr),
        .o_stall    (o_stall),
        .bus        (bus),
        .o_wb_valid (o_wb_valid),
        .o_wb_addr  (o_wb_addr),
        .o_wb_data  (o_wb_data),
        .o_misalign (o_misalign),
        .o_bus_err  (o_bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request from the IDLE cycle to the cycle after completion
    task automatic mem_txn(input string tag, input logic we, input logic [31:0] addr,
                           input logic [2:0] f3, input logic [31:0] wd, input logic [4:0] rd,
                           input int unsigned gnt_dly, input int unsigned rsp_dly,
                           input logic [31:0] rdata, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd, input logic [31:0] exp_ld);
        int unsigned stalls;
        int unsigned n_rsp;
        logic        tmo;
        logic [36:0] exp_wb;
        stalls = 0;
        tmo    = (rsp_dly >= TMO);
        n_rsp  = tmo ? TMO - 1 : rsp_dly;
        i_valid = 1'b1; i_mem_wen = we; i_mem_ren = ~we; i_mem_addr = addr;
        i_funct3 = f3; i_wdata = wd; i_rd_addr = rd;
        if (!we && !tmo) sb_q.push_back({rd, exp_ld});
        #1;
        chk1({tag, ".idle_stall"}, o_stall, 1'b1);
        chk1({tag, ".idle_req"}, bus.req, 1'b0);
        chk1({tag, ".idle_misalign"}, o_misalign, 1'b0);
        stalls += 32'(o_stall);
        tick();
        for (int unsigned c = 0; c <= gnt_dly; c++) begin
            bus.gnt = (c == gnt_dly);
            #1;
            chk1({tag, ".req"}, bus.req, 1'b1);
            chk32({tag, ".addr"}, bus.addr, {addr[31:2], 2'b00});
            chk32({tag, ".be"}, {28'b0, bus.be}, {28'b0, exp_be});
            chk1({tag, ".we"}, bus.we, we);
            if (we) chk32({tag, ".wdata"}, bus.wdata, exp_wd);
            stalls += 32'(o_stall);
            tick();
        end
        bus.gnt = 1'b0;
        for (int unsigned c = 0; c < n_rsp; c++) begin
            #1;
            chk1({tag, ".rsp_stall"}, o_stall, 1'b1);
            chk1({tag, ".rsp_req"}, bus.req, 1'b0);
            chk1({tag, ".rsp_err"}, o_bus_err, 1'b0);
            stalls += 32'(o_stall);
            tick();
        end
        if (tmo) begin
            #1;
            chk1({tag, ".tmo_err"}, o_bus_err, 1'b1);
            chk1({tag, ".tmo_stall"}, o_stall, 1'b0);
            chk1({tag, ".tmo_wb"}, o_wb_valid, 1'b0);
            chk32({tag, ".stall_cycles"}, stalls, 2 + gnt_dly + TMO - 1);
        end else begin
            bus.rvalid = 1'b1;
            bus.rdata  = rdata;
            #1;
            chk1({tag, ".done_stall"}, o_stall, 1'b0);
            chk1({tag, ".wb_valid"}, o_wb_valid, ~we);
            if (o_wb_valid === 1'b1) begin
                chk32({tag, ".sb_depth"}, 32'(sb_q.size()), 32'd1);
                if (sb_q.size() > 0) begin
                    exp_wb = sb_q.pop_front();
                    chk32({tag, ".wb_addr"}, {27'b0, o_wb_addr}, {27'b0, exp_wb[36:32]});
                    chk32({tag, ".wb_data"}, o_wb_data, exp_wb[31:0]);
                end
            end
            chk32({tag, ".stall_cycles"}, stalls, 2 + gnt_dly + rsp_dly);
        end
        tick();
        bus.rvalid = 1'b0;
        bus.rdata  = $urandom;
        i_valid    = 1'b0;
        #1;
        chk1({tag, ".after_stall"}, o_stall, 1'b0);
        chk1({tag, ".after_wb"}, o_wb_valid, 1'b0);
        chk1({tag, ".after_err"}, o_bus_err, 1'b0);
    endtask

    task automatic misalign_txn(input string tag, input logic we, input logic [31:0] addr,
                                input logic [2:0] f3);
        i_valid = 1'b1; i_mem_wen = we; i_mem_ren = ~we; i_mem_addr = addr;
        i_funct3 = f3; i_wdata = 32'h5555AAAA; i_rd_addr = 5'd3;
        #1;
        chk1({tag, ".misalign"}, o_misalign, 1'b1);
        chk1({tag, ".stall"}, o_stall, 1'b0);
        chk1({tag, ".req"}, bus.req, 1'b0);
        tick();
        i_valid = 1'b0;
        #1;
        chk1({tag, ".req_next"}, bus.req, 1'b0);
        chk1({tag, ".misalign_next"}, o_misalign, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        i_valid = 1'b0; i_mem_wen = 1'b0; i_mem_ren = 1'b0; i_mem_addr = '0;
        i_funct3 = '0; i_wdata = '0; i_rd_addr = '0;
        bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
        #1;
        chk1("rst.stall", o_stall, 1'b0);
        chk1("rst.req", bus.req, 1'b0);
        chk32("rst.addr", bus.addr, 32'h0);
        chk1("rst.wb_valid", o_wb_valid, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        mem_txn("lw_100", 1'b0, 32'h100, 3'b010, 32'h0, 5'd5, 0, 0, 32'hDEADBEEF, 4'b1111, 32'h0, 32'hDEADBEEF);
        mem_txn("lb_103", 1'b0, 32'h103, 3'b000, 32'h0, 5'd6, 0, 0, 32'h80112233, 4'b1000, 32'h0, 32'hFFFFFF80);
        mem_txn("lbu_103", 1'b0, 32'h103, 3'b100, 32'h0, 5'd7, 0, 1, 32'h80112233, 4'b1000, 32'h0, 32'h00000080);
        mem_txn("lh_102", 1'b0, 32'h102, 3'b001, 32'h0, 5'd8, 1, 0, 32'hBEEF0000, 4'b1100, 32'h0, 32'hFFFFBEEF);
        mem_txn("lhu_102", 1'b0, 32'h102, 3'b101, 32'h0, 5'd9, 1, 1, 32'hBEEF0000, 4'b1100, 32'h0, 32'h0000BEEF);
        mem_txn("lb_101", 1'b0, 32'h101, 3'b000, 32'h0, 5'd13, 0, 0, 32'h00007F00, 4'b0010, 32'h0, 32'h0000007F);
        mem_txn("sh_202", 1'b1, 32'h202, 3'b001, 32'h1234ABCD, 5'd0, 0, 0, 32'h0, 4'b1100, 32'hABCDABCD, 32'h0);
        mem_txn("sb_301", 1'b1, 32'h301, 3'b000, 32'h000000A5, 5'd0, 0, 0, 32'h0, 4'b0010, 32'hA5A5A5A5, 32'h0);
        mem_txn("sw_400", 1'b1, 32'h400, 3'b010, 32'hCAFEF00D, 5'd0, 2, 3, 32'h0, 4'b1111, 32'hCAFEF00D, 32'h0);
        mem_txn("lw_gnt5", 1'b0, 32'h500, 3'b010, 32'h0, 5'd10, 5, 2, 32'h13579BDF, 4'b1111, 32'h0, 32'h13579BDF);

        misalign_txn("mis_lw_101", 1'b0, 32'h101, 3'b010);
        misalign_txn("mis_lw_102", 1'b0, 32'h102, 3'b010);
        misalign_txn("mis_lhu_103", 1'b0, 32'h103, 3'b101);
        misalign_txn("mis_sh_201", 1'b1, 32'h201, 3'b001);
        misalign_txn("mis_sw_003", 1'b1, 32'h003, 3'b010);

        mem_txn("lw_tmo", 1'b0, 32'h600, 3'b010, 32'h0, 5'd11, 0, TMO, 32'h0, 4'b1111, 32'h0, 32'h0);

        // Abandon a load in RSP with reset, then show a stray rvalid is ignored
        i_valid = 1'b1; i_mem_wen = 1'b0; i_mem_ren = 1'b1; i_mem_addr = 32'h180;
        i_funct3 = 3'b010; i_rd_addr = 5'd14;
        tick();
        bus.gnt = 1'b1;
        tick();
        bus.gnt = 1'b0;
        tick();
        rst = 1'b1;
        i_valid = 1'b0;
        #1;
        chk1("rst_rsp.stall", o_stall, 1'b0);
        chk1("rst_rsp.req", bus.req, 1'b0);
        chk1("rst_rsp.we", bus.we, 1'b0);
        chk32("rst_rsp.addr", bus.addr, 32'h0);
        chk32("rst_rsp.be", {28'b0, bus.be}, 32'h0);
        chk32("rst_rsp.wdata", bus.wdata, 32'h0);
        chk1("rst_rsp.wb_valid", o_wb_valid, 1'b0);
        chk32("rst_rsp.wb_data", o_wb_data, 32'h0);
        chk1("rst_rsp.err", o_bus_err, 1'b0);
        chk1("rst_rsp.misalign", o_misalign, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h11111111;
        #1;
        chk1("late_rvalid.wb", o_wb_valid, 1'b0);
        chk1("late_rvalid.stall", o_stall, 1'b0);
        tick();
        bus.rvalid = 1'b0;

        mem_txn("lw_post_rst", 1'b0, 32'h700, 3'b010, 32'h0, 5'd12, 0, 0, 32'h0BADF00D, 4'b1111, 32'h0, 32'h0BADF00D);
        chk32("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
